// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: frame-stepped jump/fall trajectory with integer gravity for the dino sprite
module dino_jump_ctrl #(
    parameter int H_W       = 8,
    parameter int V_W       = 5,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int FAST_GRAV = 3,
    parameter int MAX_FALL  = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frameTick,
    input  logic [1:0]     gameState,
    input  logic           jumpBtn,
    input  logic           duckBtn,
    output logic [H_W-1:0] dinoHeight,
    output logic           Airborne,
    output logic           onGround,
    output logic           isDuck,
    output logic           landed
);
    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t         state, state_n;
    logic [V_W-1:0] vel, v_n, nv;
    logic [V_W:0]   nv_sum;
    logic [H_W-1:0] h_n;
    logic           jump_req, jb_q, rise, playing, idle, launch, landed_n, duck_n;

    assign rise    = jumpBtn & ~jb_q;
    assign playing = gameState == 2'b10;
    assign idle    = gameState[1] == gameState[0];
    assign launch  = playing & frameTick & (state == GROUND) & (jump_req | rise);
    assign nv_sum  = {1'b0, vel} + (V_W+1)'(duckBtn ? FAST_GRAV : GRAVITY);
    assign nv      = nv_sum > (V_W+1)'(MAX_FALL) ? V_W'(MAX_FALL) : nv_sum[V_W-1:0];

    // State, motion and output registers; jumpReq remembers a press until the next frame tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GROUND;
            vel        <= '0;
            dinoHeight <= '0;
            jump_req   <= 1'b0;
            jb_q       <= 1'b0;
            Airborne   <= 1'b0;
            onGround   <= 1'b1;
            isDuck     <= 1'b0;
            landed     <= 1'b0;
        end else begin
            state      <= state_n;
            vel        <= v_n;
            dinoHeight <= h_n;
            jump_req   <= frameTick ? 1'b0 : (rise ? 1'b1 : jump_req);
            jb_q       <= jumpBtn;
            Airborne   <= state_n != GROUND;
            onGround   <= state_n == GROUND;
            isDuck     <= duck_n;
            landed     <= landed_n;
        end
    end

    // Next-state and trajectory step; idle/start forces ground, game over freezes everything
    always_comb begin
        state_n  = state;
        h_n      = dinoHeight;
        v_n      = vel;
        landed_n = 1'b0;
        duck_n   = isDuck;
        if (idle) begin
            state_n = GROUND;
            h_n     = '0;
            v_n     = '0;
            duck_n  = 1'b0;
        end else if (playing) begin
            duck_n = duckBtn & (state == GROUND) & ~launch;
            if (frameTick) begin
                case (state)
                    GROUND: if (launch) begin
                        state_n = RISE;
                        h_n     = H_W'(JUMP_V0);
                        v_n     = V_W'(JUMP_V0 - GRAVITY);
                    end
                    RISE: begin
                        h_n     = dinoHeight + H_W'(vel);
                        v_n     = vel > V_W'(GRAVITY) ? vel - V_W'(GRAVITY) : '0;
                        state_n = vel > V_W'(GRAVITY) ? RISE : FALL;
                    end
                    FALL: if (dinoHeight <= H_W'(nv)) begin
                        state_n  = GROUND;
                        h_n      = '0;
                        v_n      = '0;
                        landed_n = 1'b1;
                    end else begin
                        h_n = dinoHeight - H_W'(nv);
                        v_n = nv;
                    end
                    default: state_n = GROUND;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: directed checks of the dino jump trajectory, freeze/idle and duck behaviour
module tb_dino_jump_ctrl;
    logic       clk = 0, rst = 1, frameTick = 0, jumpBtn = 0, duckBtn = 0;
    logic [1:0] gameState = 2'b00;
    logic [7:0] dinoHeight;
    logic       Airborne, onGround, isDuck, landed;
    int vectors = 0, errors = 0;
    int rise_h[12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
    int fall_h[12] = '{77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
    int duck_h[8]  = '{75, 69, 60, 48, 33, 18, 3, 0};

    dino_jump_ctrl dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .gameState(gameState),
        .jumpBtn(jumpBtn), .duckBtn(duckBtn), .dinoHeight(dinoHeight),
        .Airborne(Airborne), .onGround(onGround), .isDuck(isDuck), .landed(landed)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        frameTick = 1;
        @(negedge clk);
        frameTick = 0;
    endtask

    task automatic press();
        @(negedge clk);
        jumpBtn = 1;
        @(negedge clk);
        jumpBtn = 0;
    endtask

    task automatic to_idle();
        @(negedge clk);
        gameState = 2'b00;
        @(negedge clk);
        gameState = 2'b10;
    endtask

    task automatic test_reset();
        clk1();
        vectors++;
        if ({dinoHeight, Airborne, onGround, isDuck, landed} !== {8'd0, 4'b0100}) begin
            errors++; $display("FAIL reset_init got h=%0d a=%b g=%b d=%b l=%b exp h=0 a=0 g=1 d=0 l=0", dinoHeight, Airborne, onGround, isDuck, landed);
        end
        rst = 0;
        gameState = 2'b10;
        press();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (dinoHeight !== 8'd42 || Airborne !== 1'b1) begin
            errors++; $display("FAIL reset_prejump got h=%0d a=%b exp h=42 a=1", dinoHeight, Airborne);
        end
        rst = 1;
        clk1();
        vectors++;
        if (dinoHeight !== 8'd0 || onGround !== 1'b1 || Airborne !== 1'b0 || dut.vel !== 5'd0) begin
            errors++; $display("FAIL reset_midrise got h=%0d g=%b a=%b v=%0d exp h=0 g=1 a=0 v=0", dinoHeight, onGround, Airborne, dut.vel);
        end
        rst = 0;
        clk1();
    endtask

    task automatic test_jump();
        press();
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (dinoHeight !== 8'(rise_h[i]) || Airborne !== 1'b1 || onGround !== 1'b0 || landed !== 1'b0) begin
                errors++; $display("FAIL jump_rise t%0d got h=%0d a=%b g=%b l=%b exp h=%0d a=1 g=0 l=0", i + 1, dinoHeight, Airborne, onGround, landed, rise_h[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (dinoHeight !== 8'(fall_h[i]) || Airborne !== (i != 11) || landed !== (i == 11)) begin
                errors++; $display("FAIL jump_fall t%0d got h=%0d a=%b l=%b exp h=%0d a=%b l=%b", i + 13, dinoHeight, Airborne, landed, fall_h[i], i != 11, i == 11);
            end
        end
        clk1();
        vectors++;
        if (landed !== 1'b0 || onGround !== 1'b1) begin
            errors++; $display("FAIL jump_landed_pulse got l=%b g=%b exp l=0 g=1", landed, onGround);
        end
    endtask

    task automatic test_duck_fall();
        press();
        for (int i = 0; i < 12; i++) tick();
        duckBtn = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (dinoHeight !== 8'(duck_h[i]) || landed !== (i == 7) || isDuck !== 1'b0) begin
                errors++; $display("FAIL duck_fall t%0d got h=%0d l=%b d=%b exp h=%0d l=%b d=0", i + 13, dinoHeight, landed, isDuck, duck_h[i], i == 7);
            end
        end
        clk1();
        vectors++;
        if (isDuck !== 1'b1) begin
            errors++; $display("FAIL duck_after_land got d=%b exp d=1", isDuck);
        end
        duckBtn = 0;
        clk1();
        vectors++;
        if (isDuck !== 1'b0) begin
            errors++; $display("FAIL duck_release got d=%b exp d=0", isDuck);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        jumpBtn = 1;
        for (int i = 0; i < 24; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (dinoHeight !== 8'd0 || onGround !== 1'b1) begin
            errors++; $display("FAIL held_single_jump got h=%0d g=%b exp h=0 g=1", dinoHeight, onGround);
        end
        jumpBtn = 0;
        press();
        for (int i = 0; i < 5; i++) tick();
        press();
        for (int i = 5; i < 12; i++) tick();
        vectors++;
        if (dinoHeight !== 8'd78) begin
            errors++; $display("FAIL repress_peak got h=%0d exp 78", dinoHeight);
        end
        for (int i = 0; i < 12; i++) tick();
        tick();
        vectors++;
        if (dinoHeight !== 8'd0 || Airborne !== 1'b0) begin
            errors++; $display("FAIL repress_discarded got h=%0d a=%b exp h=0 a=0", dinoHeight, Airborne);
        end
        press();
        for (int i = 0; i < 24; i++) tick();
        press();
        tick();
        vectors++;
        if (dinoHeight !== 8'd12 || Airborne !== 1'b1) begin
            errors++; $display("FAIL repress_after_land got h=%0d a=%b exp h=12 a=1", dinoHeight, Airborne);
        end
        to_idle();
    endtask

    task automatic test_freeze();
        press();
        for (int i = 0; i < 5; i++) tick();
        gameState = 2'b01;
        for (int i = 0; i < 100; i++) tick();
        vectors++;
        if (dinoHeight !== 8'd50 || Airborne !== 1'b1 || landed !== 1'b0) begin
            errors++; $display("FAIL freeze_hold got h=%0d a=%b l=%b exp h=50 a=1 l=0", dinoHeight, Airborne, landed);
        end
        gameState = 2'b00;
        clk1();
        vectors++;
        if (dinoHeight !== 8'd0 || onGround !== 1'b1 || Airborne !== 1'b0) begin
            errors++; $display("FAIL idle_force got h=%0d g=%b a=%b exp h=0 g=1 a=0", dinoHeight, onGround, Airborne);
        end
        gameState = 2'b10;
        tick();
        vectors++;
        if (dinoHeight !== 8'd0) begin
            errors++; $display("FAIL idle_no_resume got h=%0d exp 0", dinoHeight);
        end
    endtask

    task automatic test_jump_duck();
        @(negedge clk);
        jumpBtn = 1;
        duckBtn = 1;
        frameTick = 1;
        @(negedge clk);
        frameTick = 0;
        vectors++;
        if (dinoHeight !== 8'd12 || isDuck !== 1'b0 || Airborne !== 1'b1) begin
            errors++; $display("FAIL jump_over_duck got h=%0d d=%b a=%b exp h=12 d=0 a=1", dinoHeight, isDuck, Airborne);
        end
        jumpBtn = 0;
        duckBtn = 0;
        to_idle();
        duckBtn = 1;
        clk1();
        vectors++;
        if (isDuck !== 1'b1 || dinoHeight !== 8'd0) begin
            errors++; $display("FAIL duck_ground got d=%b h=%0d exp d=1 h=0", isDuck, dinoHeight);
        end
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (dinoHeight !== 8'd0 || onGround !== 1'b1 || isDuck !== 1'b1) begin
            errors++; $display("FAIL duck_no_motion got h=%0d g=%b d=%b exp h=0 g=1 d=1", dinoHeight, onGround, isDuck);
        end
        gameState = 2'b11;
        clk1();
        vectors++;
        if (isDuck !== 1'b0) begin
            errors++; $display("FAIL duck_state11 got d=%b exp d=0", isDuck);
        end
        duckBtn = 0;
        gameState = 2'b10;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_duck_fall();
        test_back_to_back();
        test_freeze();
        test_jump_duck();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
